// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, register-field width and the NOP encoding.
package pipeline_pkg;

  localparam int          REG_W   = 5;
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hazard_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the load in EX and the source registers in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             lu
);

  // $zero never carries a real dependency, so a load targeting it cannot stall.
  assign lu = ex_memread && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-busy freezes and branch/jump flushes.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  output logic             w_IF_ID,
  output logic             w_pc,
  output logic             flush_IF_ID,
  output logic             bubble_ID_EX,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] LU_REM = 2'(LU_CYCLES - 1);

  hazard_state_e state_q, state_d;
  logic [1:0]    rem_q, rem_d;
  logic          pend_q, pend_d;
  logic          lu, redirect;
  logic          hold, flush, bubble;

  hazard_detect u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  assign redirect = branch_taken | jump;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    hold    = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      LU_STALL: begin
        if (mem_busy) begin
          // The freeze absorbs whatever stall is left; ID re-evaluates afterwards.
          hold    = 1'b1;
          pend_d  = 1'b0;
          rem_d   = '0;
          state_d = MEM_WAIT;
        end else begin
          hold   = 1'b1;
          bubble = 1'b1;
          rem_d  = rem_q - 2'd1;
          if (rem_q <= 2'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          hold   = 1'b1;
          pend_d = pend_q | redirect;
        end else begin
          flush   = pend_q;
          pend_d  = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        if (mem_busy) begin
          hold    = 1'b1;
          pend_d  = redirect;
          state_d = MEM_WAIT;
        end else if (lu) begin
          hold   = 1'b1;
          bubble = 1'b1;
          if (LU_CYCLES > 1) begin
            rem_d   = LU_REM;
            state_d = LU_STALL;
          end
        end else if (redirect) begin
          flush = 1'b1;
        end
        // The unused encoding behaves as RUN for one cycle, then settles in RUN.
        if (state_q != RUN) begin
          state_d = RUN;
          rem_d   = '0;
          pend_d  = pend_q;
        end
      end
    endcase
  end

  assign w_IF_ID      = hold & ~reset;
  assign w_pc         = hold & ~reset;
  assign flush_IF_ID  = flush & ~reset;
  assign bubble_ID_EX = bubble & ~reset;
  assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hold && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl: two instances (LU_CYCLES=1 wide counters, LU_CYCLES=3 narrow
// counters) driven in lockstep and compared every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic       branch_taken = 1'b0, jump = 1'b0, mem_busy = 1'b0;

  logic        a_w_if_id, a_w_pc, a_flush, a_bubble;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flush_cnt;
  logic        b_w_if_id, b_w_pc, b_flush, b_bubble;
  logic [1:0]  b_state;
  logic [2:0]  b_stall, b_flush_cnt;

  int compared   = 0;
  int mismatched = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int lu_cfg[2]  = '{1, 3};
  int cnt_max[2] = '{65535, 7};

  int stall_left[2];
  bit frozen[2];
  bit pend[2];
  int stall_cnt[2];
  int flush_cnt[2];

  always #5 clock = ~clock;

  hazard_ctrl #(.LU_CYCLES(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .jump(jump),
    .mem_busy(mem_busy), .w_IF_ID(a_w_if_id), .w_pc(a_w_pc), .flush_IF_ID(a_flush),
    .bubble_ID_EX(a_bubble), .state(a_state), .stall_cycles(a_stall), .flush_count(a_flush_cnt)
  );

  hazard_ctrl #(.LU_CYCLES(3), .CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken), .jump(jump),
    .mem_busy(mem_busy), .w_IF_ID(b_w_if_id), .w_pc(b_w_pc), .flush_IF_ID(b_flush),
    .bubble_ID_EX(b_bubble), .state(b_state), .stall_cycles(b_stall), .flush_count(b_flush_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [5:0] obsCtl(input int k);
    return (k == 0) ? {a_w_if_id, a_w_pc, a_flush, a_bubble, a_state}
                    : {b_w_if_id, b_w_pc, b_flush, b_bubble, b_state};
  endfunction

  function automatic logic [31:0] obsStall(input int k);
    return (k == 0) ? 32'(a_stall) : 32'(b_stall);
  endfunction

  function automatic logic [31:0] obsFlush(input int k);
    return (k == 0) ? 32'(a_flush_cnt) : 32'(b_flush_cnt);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0;
      frozen[k]     = 1'b0;
      pend[k]       = 1'b0;
      stall_cnt[k]  = 0;
      flush_cnt[k]  = 0;
    end
  endtask

  // One pipeline cycle of the reference: returns this cycle's controls and advances the model.
  task automatic modelCycle(input int k, output logic [5:0] ctl);
    bit lu, redir, hold, flush, bubble;
    logic [1:0] st;
    lu    = ex_memread && (ex_rd != 0) &&
            ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    redir = branch_taken || jump;
    st    = frozen[k] ? 2'd2 : ((stall_left[k] > 0) ? 2'd1 : 2'd0);
    hold = 0; flush = 0; bubble = 0;
    if (frozen[k]) begin
      if (mem_busy) begin
        hold = 1;
        pend[k] = pend[k] | redir;
      end else begin
        flush = pend[k];
        pend[k] = 0;
        frozen[k] = 0;
      end
    end else if (stall_left[k] > 0) begin
      hold = 1;
      if (mem_busy) begin
        frozen[k] = 1;
        pend[k] = 0;
        stall_left[k] = 0;
      end else begin
        bubble = 1;
        stall_left[k]--;
      end
    end else if (mem_busy) begin
      hold = 1;
      pend[k] = redir;
      frozen[k] = 1;
    end else if (lu) begin
      hold = 1;
      bubble = 1;
      stall_left[k] = lu_cfg[k] - 1;
    end else if (redir) begin
      flush = 1;
    end
    ctl = {hold, hold, flush, bubble, st};
    if (hold && stall_cnt[k] < cnt_max[k]) stall_cnt[k]++;
    if (flush && flush_cnt[k] < cnt_max[k]) flush_cnt[k]++;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                               input logic memread, input logic [4:0] rd, input logic br,
                               input logic jmp, input logic busy);
    logic [5:0] ctl;
    id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; ex_memread = memread; ex_rd = rd;
    branch_taken = br; jump = jmp; mem_busy = busy;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d stall_cycles", k), obsStall(k), PERF ? 32'(stall_cnt[k]) : 32'd0);
      checkOutput($sformatf("dut%0d flush_count", k), obsFlush(k), PERF ? 32'(flush_cnt[k]) : 32'd0);
      modelCycle(k, ctl);
      checkOutput($sformatf("dut%0d controls", k), 32'(obsCtl(k)), 32'(ctl));
    end
    @(posedge clock);
    #1;
  endtask

  // Reset is raised between edges with a live hazard on the inputs; outputs must clear at once.
  task automatic asyncResetCheck();
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("dut%0d reset controls", k), 32'(obsCtl(k)), 32'd0);
      checkOutput($sformatf("dut%0d reset stall_cycles", k), obsStall(k), 32'd0);
      checkOutput($sformatf("dut%0d reset flush_count", k), obsFlush(k), 32'd0);
    end
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    #1;
    for (int k = 0; k < 2; k++)
      checkOutput($sformatf("dut%0d power-on controls", k), 32'(obsCtl(k)), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] directed scenarios");
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    asyncResetCheck();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) asyncResetCheck();
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS pipeline. Generates the IF/ID write-hold, PC write-hold, IF/ID flush and ID/EX bubble controls. Resolves load-use hazards, external memory-busy freezes and taken branches/jumps, with fixed priority. Sits beside the IF/ID and ID/EX pipeline registers and drives their control inputs directly.

## Interface
- LU_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..3)
- CNT_W, 16, width of performance counters
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- branch_taken  in  1  branch in ID resolved taken
- jump  in  1  jump decoded in ID
- mem_busy  in  1  instruction/data memory not ready; freeze pipeline
- w_IF_ID  out  1  0 = IF/ID loads, 1 = IF/ID holds
- w_pc  out  1  0 = PC updates, 1 = PC holds
- flush_IF_ID  out  1  1 = IF/ID loads 32'h0000_0000 (NOP) on next edge
- bubble_ID_EX  out  1  1 = ID/EX loads NOP control
- state  out  2  current FSM state
- stall_cycles  out  CNT_W  stall-cycle count
- flush_count  out  CNT_W  flush count

## Operation
- lu = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- Outputs are combinational from state and inputs (Mealy). Default: all four controls 0.
- States: RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10. 2'b11 is illegal; it is treated as RUN and the next edge moves to RUN.
- Priority in RUN: mem_busy > lu > (branch_taken | jump).
- RUN, mem_busy=1: w_IF_ID=1, w_pc=1, bubble=0. Latch pend = branch_taken|jump. Go to MEM_WAIT.
- RUN, lu=1: w_IF_ID=1, w_pc=1, bubble_ID_EX=1. If LU_CYCLES>1, load rem=LU_CYCLES-1 and go to LU_STALL; otherwise stay in RUN.
- RUN, branch_taken|jump: flush_IF_ID=1, w_IF_ID=0, w_pc=0. Stay in RUN.
- LU_STALL, mem_busy=1: go to MEM_WAIT; pend is cleared. The stall then completes via the freeze.
- LU_STALL, otherwise: w_IF_ID=1, w_pc=1, bubble=1. Decrement rem; at rem==1 return to RUN.
- MEM_WAIT, mem_busy=1: hold IF/ID and PC, no bubble. pend |= branch_taken|jump.
- MEM_WAIT, mem_busy=0: if pend, assert flush_IF_ID=1 this cycle. Clear pend. Go to RUN.
- flush_IF_ID and w_IF_ID=1 are never asserted in the same cycle.

## Timing
- Reset (async, any state, mid-stall included): state=RUN, rem=0, pend=0, counters=0. Outputs read 0 while reset is asserted.
- Load-use: exactly LU_CYCLES consecutive cycles with w_IF_ID=1 and bubble=1, absent mem_busy.
- Branch/jump: one flush cycle, zero added stall.
- mem_busy freeze: adds exactly the busy cycles. A pending flush fires in the first non-busy cycle.
- Counters increment on the clock edge ending any cycle with w_pc=1 (stall_cycles) or flush_IF_ID=1 (flush_count). Both saturate at all-ones.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles and flush_count are implemented as specified.
- HAZARD_PERF_CNT_EN undefined: counter registers are omitted; both ports are tied to 0.
- Control behaviour is identical either way.

## Structure
- Shared package pipeline_pkg holds:
  - the state enum (RUN, LU_STALL, MEM_WAIT);
  - REG_W=5;
  - NOP_INS=32'h0000_0000.
- Sub-module hazard_detect: purely combinational lu comparator, reusable by the forwarding unit.
- The FSM, rem/pend registers and counters live in hazard_ctrl.

## Test plan
- Load-use on rs: ex_memread=1, ex_rd=5, id_rs=5, LU_CYCLES=1 -> one cycle with w_IF_ID=1, w_pc=1, bubble=1, then controls 0; stall_cycles=1.
- ex_rd=0 with id_rs=0, or rt match with id_uses_rt=0 -> no stall.
- LU_CYCLES=3: hazard in cycle 0 -> stall in cycles 0,1,2; RUN in cycle 3.
- jump=1 in RUN -> flush_IF_ID=1 for one cycle, w_IF_ID=0; flush_count=1; IF/ID reads 32'h0000_0000 next cycle.
- mem_busy high 4 cycles, branch_taken pulsed in the 2nd -> w_IF_ID=1 for 4 cycles, then flush_IF_ID=1 in cycle 5; simultaneous lu+branch in RUN -> stall wins, flush deferred until ID re-presents the branch.
- reset asserted mid-LU_STALL (LU_CYCLES=3) -> state=00 and all outputs 0 immediately, without waiting for a clock edge.
